// File: rtl/alu.sv
// Registered two's-complement ALU: ADD/SUB/MUL/DIV/AND/OR/XOR/NOT with an overflow/illegal-op flag.
// Define ALU_DIV_EN to build the combinational signed divider; otherwise opcode 011 is illegal.
module alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Opcode,
   output logic [WIDTH-1:0] Result,
   output logic             Error
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_NOT = 3'b111
   } op_e;

   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0]          sum;
   logic [WIDTH-1:0]          diff;
   logic signed [2*WIDTH-1:0] prod;
   logic [WIDTH:0]            prod_hi;
   logic [WIDTH-1:0]          res_d;
   logic                      err_d;

   assign sum     = A + B;
   assign diff    = A - B;
   assign prod    = (2*WIDTH)'($signed(A)) * (2*WIDTH)'($signed(B));
   // Product fits in WIDTH signed bits only if the top WIDTH+1 bits are all sign copies
   assign prod_hi = prod[2*WIDTH-1:WIDTH-1];

   always_comb begin
      res_d = '0;
      err_d = 1'b0;
      case (Opcode)
         OP_ADD: begin
            res_d = sum;
            err_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            res_d = diff;
            err_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_MUL: begin
            res_d = prod[WIDTH-1:0];
            err_d = !((&prod_hi) || !(|prod_hi));
         end
         OP_DIV: begin
`ifdef ALU_DIV_EN
            if (B == '0) begin
               res_d = '0;
               err_d = 1'b1;
            end else if ((A == MIN_INT) && (B == '1)) begin
               res_d = MIN_INT;
               err_d = 1'b1;
            end else begin
               res_d = $signed(A) / $signed(B);
            end
`else
            res_d = '0;
            err_d = 1'b1;
`endif
         end
         OP_AND: res_d = A & B;
         OP_OR:  res_d = A | B;
         OP_XOR: res_d = A ^ B;
         OP_NOT: res_d = ~A;
         // Reached only for an unknown opcode in simulation
         default: begin
            res_d = '0;
            err_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Result <= '0;
         Error  <= 1'b0;
      end else begin
         Result <= res_d;
         Error  <= err_d;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at drive time (negedge), popped and checked after each posedge.
// Expectations for opcode 011 follow whether ALU_DIV_EN is defined.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  Opcode;
   logic [31:0] Result;
   logic        Error;

   typedef struct {
      string       tag;
      logic [31:0] r;
      logic        e;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   alu #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .B      (B),
      .Opcode (Opcode),
      .Result (Result),
      .Error  (Error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference built on 64-bit integer arithmetic with explicit range tests
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                 output logic [31:0] r, output logic e);
      longint sa, sb_, t;
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      r = '0;
      e = 1'b0;
      case (op)
         3'd0: begin t = sa + sb_; r = t[31:0]; e = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         3'd1: begin t = sa - sb_; r = t[31:0]; e = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         3'd2: begin t = sa * sb_; r = t[31:0]; e = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         3'd3: begin
`ifdef ALU_DIV_EN
            if (sb_ == 0) begin r = '0; e = 1'b1; end
            else if (sa == -64'sd2147483648 && sb_ == -64'sd1) begin r = 32'h8000_0000; e = 1'b1; end
            else begin t = sa / sb_; r = t[31:0]; end
`else
            r = '0; e = 1'b1;
`endif
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = ~a;
      endcase
   endfunction

   task automatic drive(input logic r_, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [31:0] er, input logic ee, input string tag);
      @(negedge clk);
      rst = r_;
      A = a;
      B = b;
      Opcode = op;
      sb.push_back('{tag, er, ee});
   endtask

   task automatic drive_m(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input string tag);
      logic [31:0] er;
      logic        ee;
      model(a, b, op, er, ee);
      drive(1'b0, a, b, op, er, ee, tag);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         check({x.tag, "_res"}, Result, x.r);
         check({x.tag, "_err"}, {31'b0, Error}, {31'b0, x.e});
      end
   end

   initial begin
      rst = 1'b1;
      A = '0;
      B = '0;
      Opcode = '0;

      // reset holds outputs at zero regardless of inputs
      drive(1'b1, 32'd5, 32'd3, 3'd0, 32'd0, 1'b0, "rst0");
      drive(1'b1, 32'd5, 32'd3, 3'd0, 32'd0, 1'b0, "rst1");
      drive(1'b0, 32'd5, 32'd3, 3'd0, 32'd8, 1'b0, "add_first");

      drive(1'b0, 32'h7FFF_FFFF, 32'd1, 3'd0, 32'h8000_0000, 1'b1, "add_ovf");
      drive(1'b0, -32'sd5, 32'd3, 3'd1, 32'hFFFF_FFF8, 1'b0, "sub_neg");
      drive(1'b0, 32'h8000_0000, 32'd1, 3'd1, 32'h7FFF_FFFF, 1'b1, "sub_ovf");

      drive(1'b0, 32'h0001_0000, 32'h0001_0000, 3'd2, 32'd0, 1'b1, "mul_ovf");
      drive(1'b0, -32'sd7, 32'd6, 3'd2, 32'hFFFF_FFD6, 1'b0, "mul_neg");

`ifdef ALU_DIV_EN
      drive(1'b0, -32'sd7, 32'd2, 3'd3, 32'hFFFF_FFFD, 1'b0, "div_trunc");
      drive(1'b0, 32'd5, 32'd0, 3'd3, 32'd0, 1'b1, "div_zero");
      drive(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 32'h8000_0000, 1'b1, "div_minneg1");
`else
      drive(1'b0, 32'd9, 32'd3, 3'd3, 32'd0, 1'b1, "div_illegal");
      drive(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 32'd0, 1'b1, "div_illegal2");
`endif

      drive(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 32'h00F0_00F0, 1'b0, "and");
      drive(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd5, 32'hFFF0_FFF0, 1'b0, "or");
      drive(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd6, 32'hFF00_FF00, 1'b0, "xor");
      drive(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd7, 32'h0F0F_0F0F, 1'b0, "not");

      // back-to-back sweep of all opcodes, then overflow followed by a clean op
      for (int unsigned i = 0; i < 8; i++)
         drive_m(32'h7FFF_FFFF, 32'd3, 3'(i), $sformatf("b2b%0d", i));
      drive(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd0, 32'hFFFF_FFFE, 1'b1, "ovf_then");
      drive(1'b0, 32'd1, 32'd2, 3'd0, 32'd3, 1'b0, "clean_after");

      // reset mid-stream discards the overflowing op captured with it
      drive(1'b1, 32'h7FFF_FFFF, 32'd1, 3'd0, 32'd0, 1'b0, "midrst");
      drive(1'b0, 32'd2, 32'd3, 3'd2, 32'd6, 1'b0, "post_rst");

      for (int unsigned i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if (i % 5 == 0) ra = 32'h8000_0000;
         drive_m(ra, rb, 3'($urandom_range(0, 7)), $sformatf("rnd%0d", i));
      end

      for (int unsigned w = 0; w < 10 && sb.size() > 0; w++)
         @(posedge clk);
      #2;
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
